regbank_write_arbiter: RTL and testbench

Round-robin arbiter that shares the single write port (WE3/A3/WD3) of the 16-entry register bank among N_REQ writeback sources, such as the scalar ALU, the vector unit and the load path. Each cycle it grants at most one requester through a valid/ready handshake and registers the winning write onto the bank port. It also drops writes to protected registers, such as the boot-initialised R0/R15 base pointers, and flags each drop. A freeze input stalls new grants while the pipeline is held.

---
 rtl/regbank_write_arbiter_if.sv | 27 ++
 rtl/regbank_write_arbiter.sv | 144 ++++++++++++++
 tb/tb_regbank_write_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/regbank_write_arbiter_if.sv
// Write-port bus between the writeback requesters and the register bank arbiter.
// Carries the per-requester valid/ready handshake and the registered bank write port.
interface regbank_write_arbiter_if #(
    parameter int BITS  = 32,
    parameter int N_REQ = 3
);
    logic [N_REQ-1:0]      REQ_VALID;
    logic [4*N_REQ-1:0]    REQ_ADDR;
    logic [BITS*N_REQ-1:0] REQ_DATA;
    logic [N_REQ-1:0]      REQ_READY;
    logic                  WE3;
    logic [3:0]            A3;
    logic [BITS-1:0]       WD3;
    logic [15:0]           PENDING;

    // Requester side: drives requests, observes grants and the bank port.
    modport master (
        output REQ_VALID, REQ_ADDR, REQ_DATA,
        input  REQ_READY, WE3, A3, WD3, PENDING
    );

    // Arbiter side: receives requests, drives grants and the bank port.
    modport slave (
        input  REQ_VALID, REQ_ADDR, REQ_DATA,
        output REQ_READY, WE3, A3, WD3, PENDING
    );
endinterface

// File: rtl/regbank_write_arbiter.sv
// Round-robin arbiter sharing the single register-bank write port among N_REQ
// writeback sources. One grant per cycle, registered write onto WE3/A3/WD3,
// writes to protected registers are dropped and reported through ERR/ERR_ID.
module regbank_write_arbiter #(
    parameter int          BITS         = 32,
    parameter int          N_REQ        = 3,
    parameter logic [15:0] PROTECT_MASK = 16'h8001
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    FREEZE,
    regbank_write_arbiter_if.slave  bus,
    output logic                    ERR,
    output logic [2:0]              ERR_ID
);

    localparam logic [2:0] LAST_IDX = 3'(N_REQ - 1);
    localparam logic [3:0] N_REQ_W4 = 4'(N_REQ);

    // State flops
    logic [2:0]      p_q,      p_d;
    logic            we3_q,    we3_d;
    logic [3:0]      a3_q,     a3_d;
    logic [BITS-1:0] wd3_q,    wd3_d;
    logic            err_q,    err_d;
    logic [2:0]      err_id_q, err_id_d;

    // Arbitration signals
    logic [7:0]       valid_pad_s;
    logic [3:0]       cand_s;
    logic             grant_s;
    logic [2:0]       grant_idx_s;
    logic [3:0]       win_addr_s;
    logic [BITS-1:0]  win_data_s;
    logic [N_REQ-1:0] ready_s;
    logic [15:0]      pending_s;

    // Pad the request vector to 8 so a 3-bit candidate index is always in range.
    always_comb begin
        valid_pad_s              = 8'd0;
        valid_pad_s[N_REQ-1:0]   = bus.REQ_VALID;
    end

    // Round-robin search starting at the pointer; no grant in reset or while frozen.
    always_comb begin
        grant_s     = 1'b0;
        grant_idx_s = 3'd0;
        cand_s      = 4'd0;
        for (int k = 0; k < N_REQ; k++) begin
            cand_s = 4'(p_q) + 4'(k);
            if (cand_s >= N_REQ_W4) begin
                cand_s = cand_s - N_REQ_W4;
            end else begin
                cand_s = cand_s;
            end
            if (!grant_s && valid_pad_s[cand_s[2:0]] && RST_N && !FREEZE) begin
                grant_s     = 1'b1;
                grant_idx_s = cand_s[2:0];
            end else begin
                grant_s     = grant_s;
            end
        end
    end

    // Select the winner's address/data and raise its ready.
    always_comb begin
        win_addr_s = 4'd0;
        win_data_s = {BITS{1'b0}};
        ready_s    = {N_REQ{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_s && (grant_idx_s == 3'(i))) begin
                win_addr_s = bus.REQ_ADDR[4*i +: 4];
                win_data_s = bus.REQ_DATA[BITS*i +: BITS];
                ready_s[i] = 1'b1;
            end else begin
                ready_s[i] = 1'b0;
            end
        end
    end

    // Next pointer and output-stage values; protected targets are consumed but not written.
    always_comb begin
        p_d      = p_q;
        we3_d    = 1'b0;
        a3_d     = a3_q;
        wd3_d    = wd3_q;
        err_d    = 1'b0;
        err_id_d = err_id_q;
        if (grant_s) begin
            if (grant_idx_s == LAST_IDX) begin
                p_d = 3'd0;
            end else begin
                p_d = grant_idx_s + 3'd1;
            end
            if (PROTECT_MASK[win_addr_s]) begin
                err_d    = 1'b1;
                err_id_d = grant_idx_s;
            end else begin
                we3_d = 1'b1;
                a3_d  = win_addr_s;
                wd3_d = win_data_s;
            end
        end else begin
            p_d = p_q;
        end
    end

    // State register; asynchronous reset discards any in-flight write.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            p_q      <= 3'd0;
            we3_q    <= 1'b0;
            a3_q     <= 4'd0;
            wd3_q    <= {BITS{1'b0}};
            err_q    <= 1'b0;
            err_id_q <= 3'd0;
        end else begin
            p_q      <= p_d;
            we3_q    <= we3_d;
            a3_q     <= a3_d;
            wd3_q    <= wd3_d;
            err_q    <= err_d;
            err_id_q <= err_id_d;
        end
    end

    // Hazard vector for the read path: one-hot of the address being written this cycle.
    always_comb begin
        if (we3_q) begin
            pending_s = 16'd1 << a3_q;
        end else begin
            pending_s = 16'd0;
        end
    end

    assign bus.REQ_READY = ready_s;
    assign bus.WE3       = we3_q;
    assign bus.A3        = a3_q;
    assign bus.WD3       = wd3_q;
    assign bus.PENDING   = pending_s;
    assign ERR           = err_q;
    assign ERR_ID        = err_id_q;

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Directed bench for regbank_write_arbiter: single write, round robin, protected
// drop, freeze, asynchronous reset mid-write and same-address conflict.
module tb_regbank_write_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       freeze;
    logic       err;
    logic [2:0] err_id;
    logic       bank_clr;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] bank [16];
    logic [2:0]  hold_q;
    logic [3:0]  prev_addr [3];
    logic [31:0] prev_data [3];

    regbank_write_arbiter_if #(.BITS(32), .N_REQ(3)) bus ();

    regbank_write_arbiter #(
        .BITS(32), .N_REQ(3), .PROTECT_MASK(16'h8001)
    ) dut (
        .CLK    (clk),
        .RST_N  (rst_n),
        .FREEZE (freeze),
        .bus    (bus),
        .ERR    (err),
        .ERR_ID (err_id)
    );

    always #5 clk = ~clk;

    // Register bank model: R15 holds its boot value, other entries start at zero.
    always @(posedge clk) begin
        if (bank_clr) begin
            for (int r = 0; r < 16; r++) bank[r] <= 32'd0;
            bank[15] <= 32'd81928;
        end else if (bus.WE3) begin
            bank[bus.A3] <= bus.WD3;
        end
    end

    // Requester obligation: a pending request keeps its address and data until granted.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst_n && hold_q[i] && bus.REQ_VALID[i]) begin
                assert (bus.REQ_ADDR[4*i +: 4] === prev_addr[i] &&
                        bus.REQ_DATA[32*i +: 32] === prev_data[i])
                    else $error("FAIL req_stable[%0d]: request changed before transfer", i);
            end
            hold_q[i]    <= rst_n && bus.REQ_VALID[i] && !bus.REQ_READY[i];
            prev_addr[i] <= bus.REQ_ADDR[4*i +: 4];
            prev_data[i] <= bus.REQ_DATA[32*i +: 32];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
            else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] a, input logic [31:0] d);
        bus.REQ_ADDR[4*i +: 4]   = a;
        bus.REQ_DATA[32*i +: 32] = d;
    endtask

    initial begin
        rst_n         = 1'b1;
        freeze        = 1'b0;
        bank_clr      = 1'b1;
        bus.REQ_VALID = 3'b000;
        bus.REQ_ADDR  = 12'd0;
        bus.REQ_DATA  = 96'd0;
        #1 rst_n = 1'b0;
        bus.REQ_VALID = 3'b111;
        #1;
        // Reset state
        chk("rst_ready",   32'(bus.REQ_READY), 32'd0);
        chk("rst_we3",     32'(bus.WE3),       32'd0);
        chk("rst_a3",      32'(bus.A3),        32'd0);
        chk("rst_wd3",     bus.WD3,            32'd0);
        chk("rst_pending", 32'(bus.PENDING),   32'd0);
        chk("rst_err",     32'(err),           32'd0);
        chk("rst_err_id",  32'(err_id),        32'd0);
        tick();
        bus.REQ_VALID = 3'b000;
        tick();
        bank_clr = 1'b0;
        rst_n    = 1'b1;

        // Single request: requester 1 writes R5
        set_req(1, 4'd5, 32'hDEAD_BEEF);
        bus.REQ_VALID = 3'b010;
        #1 chk("single_ready", 32'(bus.REQ_READY), 32'h2);
        tick();
        bus.REQ_VALID = 3'b000;
        chk("single_we3",     32'(bus.WE3),     32'd1);
        chk("single_a3",      32'(bus.A3),      32'd5);
        chk("single_wd3",     bus.WD3,          32'hDEAD_BEEF);
        chk("single_pending", 32'(bus.PENDING), 32'h0020);
        tick();
        chk("single_we3_off", 32'(bus.WE3),     32'd0);
        chk("single_pend_off",32'(bus.PENDING), 32'd0);
        chk("single_bank_r5", bank[5],          32'hDEAD_BEEF);

        // Round robin from a fresh reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        set_req(0, 4'd1, 32'd100);
        set_req(1, 4'd2, 32'd101);
        set_req(2, 4'd3, 32'd102);
        bus.REQ_VALID = 3'b111;
        for (int c = 0; c < 6; c++) begin
            #1 chk("rr_ready", 32'(bus.REQ_READY), 32'd1 << (c % 3));
            tick();
            chk("rr_we3", 32'(bus.WE3), 32'd1);
            chk("rr_a3",  32'(bus.A3),  32'((c % 3) + 1));
            chk("rr_wd3", bus.WD3,      32'(100 + (c % 3)));
        end
        bus.REQ_VALID = 3'b000;
        tick();
        chk("rr_we3_off", 32'(bus.WE3), 32'd0);

        // Protected drop: requester 2 writes R15
        set_req(2, 4'd15, 32'h1234);
        bus.REQ_VALID = 3'b100;
        #1 chk("prot_ready", 32'(bus.REQ_READY), 32'h4);
        tick();
        bus.REQ_VALID = 3'b000;
        chk("prot_we3",    32'(bus.WE3), 32'd0);
        chk("prot_err",    32'(err),     32'd1);
        chk("prot_err_id", 32'(err_id),  32'd2);
        chk("prot_a3",     32'(bus.A3),  32'd3);
        chk("prot_wd3",    bus.WD3,      32'd102);
        tick();
        chk("prot_err_off",  32'(err),    32'd0);
        chk("prot_id_hold",  32'(err_id), 32'd2);
        chk("prot_bank_r15", bank[15],    32'd81928);

        // Freeze after a grant to requester 0
        set_req(2, 4'd3, 32'd102);
        bus.REQ_VALID = 3'b111;
        #1 chk("frz_ready0", 32'(bus.REQ_READY), 32'h1);
        tick();
        chk("frz_we3_pulse", 32'(bus.WE3), 32'd1);
        chk("frz_a3_pulse",  32'(bus.A3),  32'd1);
        freeze = 1'b1;
        for (int f = 0; f < 3; f++) begin
            #1 chk("frz_ready_off", 32'(bus.REQ_READY), 32'd0);
            tick();
            chk("frz_we3_off", 32'(bus.WE3), 32'd0);
        end
        freeze = 1'b0;
        #1 chk("frz_resume_ready", 32'(bus.REQ_READY), 32'h2);
        tick();
        bus.REQ_VALID = 3'b000;
        chk("frz_resume_a3", 32'(bus.A3), 32'd2);
        tick();

        // Asynchronous reset while a write to R7 is on the port
        set_req(1, 4'd7, 32'd77);
        set_req(2, 4'd2, 32'd202);
        bus.REQ_VALID = 3'b010;
        #1 chk("mid_ready", 32'(bus.REQ_READY), 32'h2);
        tick();
        bus.REQ_VALID = 3'b000;
        chk("mid_we3_pre",  32'(bus.WE3),     32'd1);
        chk("mid_pend_pre", 32'(bus.PENDING), 32'h0080);
        #2 rst_n = 1'b0;
        bus.REQ_VALID = 3'b110;
        #1;
        chk("mid_we3",     32'(bus.WE3),       32'd0);
        chk("mid_a3",      32'(bus.A3),        32'd0);
        chk("mid_wd3",     bus.WD3,            32'd0);
        chk("mid_pending", 32'(bus.PENDING),   32'd0);
        chk("mid_err_id",  32'(err_id),        32'd0);
        chk("mid_ready0",  32'(bus.REQ_READY), 32'd0);
        tick();
        chk("mid_bank_r7", bank[7], 32'd0);
        rst_n = 1'b1;
        #1 chk("mid_ptr_reset", 32'(bus.REQ_READY), 32'h2);
        bus.REQ_VALID = 3'b100;
        #1 chk("mid_req2_ready", 32'(bus.REQ_READY), 32'h4);
        tick();
        bus.REQ_VALID = 3'b000;
        chk("mid_req2_we3", 32'(bus.WE3), 32'd1);
        chk("mid_req2_a3",  32'(bus.A3),  32'd2);
        chk("mid_req2_wd3", bus.WD3,      32'd202);

        // Same address from requesters 0 and 1; search restarts at 0
        set_req(0, 4'd4, 32'd11);
        set_req(1, 4'd4, 32'd22);
        bus.REQ_VALID = 3'b011;
        #1 chk("same_ready0", 32'(bus.REQ_READY), 32'h1);
        tick();
        bus.REQ_VALID = 3'b010;
        chk("same_we3_a", 32'(bus.WE3), 32'd1);
        chk("same_a3_a",  32'(bus.A3),  32'd4);
        chk("same_wd3_a", bus.WD3,      32'd11);
        #1 chk("same_ready1", 32'(bus.REQ_READY), 32'h2);
        tick();
        bus.REQ_VALID = 3'b000;
        chk("same_we3_b",  32'(bus.WE3),     32'd1);
        chk("same_wd3_b",  bus.WD3,          32'd22);
        chk("same_pend_b", 32'(bus.PENDING), 32'h0010);
        tick();
        chk("same_we3_off", 32'(bus.WE3), 32'd0);
        chk("same_bank_r4", bank[4],      32'd22);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
